// File: rtl/pwm_fan_pkg.sv
// Shared types and elaboration helpers for the multi-channel PWM fan controller.
// Optional kick-start behaviour is selected with the PWM_FAN_KICK_EN macro.
package pwm_fan_pkg;

  localparam int STATE_W    = 2;
  localparam int DEF_PERIOD = 100;

  typedef enum logic [STATE_W-1:0] {
    CH_IDLE = 2'd0,
    CH_KICK = 2'd1,
    CH_RUN  = 2'd2
  } ch_state_e;

  function automatic int cnt_width(input int period);
    return $clog2(period + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_PERIOD);

  // Evenly spaced duties from 0 up to max_duty, rounded down.
  function automatic int level_duty(input int level, input int max_duty, input int num_levels);
    return (level * max_duty) / (num_levels - 1);
  endfunction

  function automatic int kick_width(input int kick_periods);
    return (kick_periods < 1) ? 1 : $clog2(kick_periods + 1);
  endfunction

endpackage

// File: rtl/pwm_fan_channel.sv
// One PWM channel: speed-code target, soft-ramped active duty and output compare.
// With PWM_FAN_KICK_EN defined, a full-on kick precedes ramping from standstill.
module pwm_fan_channel
  import pwm_fan_pkg::*;
#(
  parameter int PERIOD       = 100,
  parameter int LEVEL_W      = 2,
  parameter int MAX_DUTY     = 90,
  parameter int RAMP_STEP    = 10,
  parameter int KICK_PERIODS = 3,
  parameter int CNT_W        = cnt_width(PERIOD)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               boundary_i,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               pwm_o,
  output logic               ramping_o,
  output ch_state_e          state_o
);

  localparam int NUM_LEVELS = 2 ** LEVEL_W;
  localparam int STEP_CLAMP = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(STEP_CLAMP);

  logic [CNT_W-1:0] duty_lut [NUM_LEVELS];
  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lut
    assign duty_lut[l] = CNT_W'(level_duty(l, MAX_DUTY, NUM_LEVELS));
  end

  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] act_q;
  logic [CNT_W-1:0] slew_d;
  logic             pwm_q;
  logic             ramping_q;

  // Differences are compared before adding/subtracting so the step never overshoots or wraps.
  always_comb begin
    slew_d = act_q;
    if (RAMP_STEP == 0) begin
      slew_d = target_q;
    end else if (target_q > act_q) begin
      slew_d = ((target_q - act_q) > STEP) ? act_q + STEP : target_q;
    end else if (target_q < act_q) begin
      slew_d = ((act_q - target_q) > STEP) ? act_q - STEP : target_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= '0;
    end else begin
      target_q <= duty_lut[level_i];
    end
  end

`ifdef PWM_FAN_KICK_EN
  localparam int KICK_W = kick_width(KICK_PERIODS);
  localparam logic [KICK_W-1:0] KICK_LOAD = KICK_W'(KICK_PERIODS);

  ch_state_e        state_q;
  logic [KICK_W-1:0] kick_cnt_q;
  logic [CNT_W-1:0] kick_exit;

  assign kick_exit = (RAMP_STEP == 0 || target_q < STEP) ? target_q : STEP;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CH_IDLE;
      kick_cnt_q <= '0;
      act_q      <= '0;
      pwm_q      <= 1'b0;
      ramping_q  <= 1'b0;
    end else begin
      pwm_q     <= en_i && ((state_q == CH_KICK) || (cnt_i < act_q));
      ramping_q <= (state_q == CH_KICK) || (act_q != target_q);
      if (!en_i || (state_q == CH_KICK && target_q == '0)) begin
        state_q    <= CH_IDLE;
        kick_cnt_q <= '0;
        act_q      <= '0;
      end else if (boundary_i) begin
        if (state_q == CH_KICK) begin
          kick_cnt_q <= kick_cnt_q - KICK_W'(1);
          if (kick_cnt_q == KICK_W'(1)) begin
            state_q <= CH_RUN;
            act_q   <= kick_exit;
          end
        end else if (KICK_PERIODS > 0 && act_q == '0 && target_q != '0) begin
          state_q    <= CH_KICK;
          kick_cnt_q <= KICK_LOAD;
        end else begin
          act_q   <= slew_d;
          state_q <= (slew_d == '0) ? CH_IDLE : CH_RUN;
        end
      end
    end
  end

  assign state_o = state_q;
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q     <= '0;
      pwm_q     <= 1'b0;
      ramping_q <= 1'b0;
    end else begin
      pwm_q     <= en_i && (cnt_i < act_q);
      ramping_q <= (act_q != target_q);
      if (!en_i) begin
        act_q <= '0;
      end else if (boundary_i) begin
        act_q <= slew_d;
      end
    end
  end

  assign state_o = (act_q == '0) ? CH_IDLE : CH_RUN;
`endif

  assign pwm_o     = pwm_q;
  assign ramping_o = ramping_q;

endmodule

// File: rtl/pwm_fan_ctrl.sv
// Multi-channel PWM fan controller: shared period counter, enable and period-start pulse.
// Define PWM_FAN_KICK_EN to add the spin-up kick in every channel.
module pwm_fan_ctrl
  import pwm_fan_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int PERIOD       = 100,
  parameter int LEVEL_W      = 2,
  parameter int MAX_DUTY     = 90,
  parameter int RAMP_STEP    = 10,
  parameter int KICK_PERIODS = 3
) (
  input  logic                        i_100kHz,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic [NUM_CH*LEVEL_W-1:0]   i_speed,
  output logic [NUM_CH-1:0]           o_pwm,
  output logic [NUM_CH-1:0]           o_ramping,
  output logic                        o_period_start,
  output logic [NUM_CH*STATE_W-1:0]   o_ch_state
);

  localparam int CNT_W = cnt_width(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ps_q;
  logic             boundary;

  assign cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  assign boundary = i_en && (cnt_q == CNT_LAST);

  // Disabling parks the counter at 0 so re-enable starts a fresh period.
  always_ff @(posedge i_100kHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else if (!i_en) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= (cnt_q == '0);
    end
  end

  assign o_period_start = ps_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e ch_state;

    pwm_fan_channel #(
      .PERIOD       (PERIOD),
      .LEVEL_W      (LEVEL_W),
      .MAX_DUTY     (MAX_DUTY),
      .RAMP_STEP    (RAMP_STEP),
      .KICK_PERIODS (KICK_PERIODS),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_i      (i_100kHz),
      .rst_ni     (i_rst_n),
      .en_i       (i_en),
      .boundary_i (boundary),
      .cnt_i      (cnt_q),
      .level_i    (i_speed[c*LEVEL_W +: LEVEL_W]),
      .pwm_o      (o_pwm[c]),
      .ramping_o  (o_ramping[c]),
      .state_o    (ch_state)
    );

    assign o_ch_state[c*STATE_W +: STATE_W] = ch_state;
  end

endmodule
